alu_bus_responder: RTL and testbench
====================================

Name: alu_bus_responder

Overview:
- Responder side of the 4-bit ALU core's BUSREQ protocol. It services operand and register-read requests that the core issues on its uo_out[3:0] request nibble.
- Holds a DEPTH x 4-bit register file, a small host-loaded operand-index FIFO, and write-back of the core's result and carry when the core signals done.
- Sits between the core's tt_um pins and the host/test harness, replacing the bench-side register emulation.

Parameters:
- DEPTH, 16, number of 4-bit registers (power of 2, max 16; index is always 4 bits, upper indices alias modulo DEPTH)
- QDEPTH, 4, operand-index FIFO entries (power of 2)
- DEFAULT_OPND, 3, index presented on NEXT_OPERAND when the FIFO is empty

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- busreq  in  4  core request nibble (core uo_out[3:0])
- rd_idx  in  4  register index currently on the instruction upper nibble (ui_in[7:4])
- opnd_idx  out  4  operand index to drive onto ui_in[7:4]
- opnd_drive  out  1  high while opnd_idx must own ui_in[7:4]
- rd_data  out  4  register data to core (uio_in[3:0])
- core_done  in  1  core done (uio_out[7])
- core_carry  in  1  core carry/borrow (uio_out[6])
- core_result  in  4  core result (uio_out[3:0])
- wb_en  in  1  enable result write-back
- wb_idx  in  4  write-back destination register
- host_we  in  1  host register write strobe
- host_addr  in  4  host register address
- host_wdata  in  4  host write data
- host_rdata  out  4  combinational read of reg[host_addr]
- q_push  in  1  push q_wdata into operand FIFO
- q_wdata  in  4  operand index to queue
- q_full  out  1  FIFO full
- q_empty  out  1  FIFO empty
- carry_flag  out  1  last written-back carry
- err  out  1  sticky: unknown busreq code or push while full

Behaviour:
- Reset (async, rst_n=0): all registers 0, FIFO empty (q_empty=1, q_full=0), opnd_idx=0, opnd_drive=0, rd_data=0, carry_flag=0, err=0, busreq_q=0, done_q=0.
- busreq_q samples busreq every cycle. A request is accepted at a rising edge where busreq != busreq_q. The response is registered on that same edge (1-cycle latency). A held code is never re-serviced.
- Codes:
  - 0000 IDLE: opnd_drive <= 0; rd_data holds.
  - 0011 NEXT_OPERAND: if the FIFO is non-empty, opnd_idx <= head and pop; else opnd_idx <= DEFAULT_OPND. opnd_drive <= 1.
  - 0001 READ_REG: rd_data <= reg[rd_idx]. When opnd_drive=1, rd_idx is the index just presented. opnd_drive holds.
  - Any other nonzero code: no action, err <= 1.
- Write-back: done_q samples core_done each cycle. On an edge where core_done=1 and done_q=0:
  - carry_flag <= core_carry.
  - If wb_en, reg[wb_idx] <= core_result.
- Host write: on host_we, reg[host_addr] <= host_wdata.
  - Same cycle and same address as a write-back: the write-back wins.
  - Different addresses: both writes happen.
- A READ_REG accepted in the same cycle as a write to the same index returns the old value (no bypass).
- FIFO: circular, log2(QDEPTH)+1-bit pointers.
  - Push when full: dropped, err <= 1.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted and no error is raised.
  - Push and pop in the same cycle when empty: the pop sees empty and uses DEFAULT_OPND; the push is stored.
- err clears only on reset.
- Reset mid-request: all state returns to reset values immediately. A busreq still held after reset deassertion is re-accepted on the first edge, because busreq_q=0.

Test Plan:
- Host writes R1=4, R2=5, R3=6, R4=3. busreq 0000->0011 with the FIFO empty: after 1 edge opnd_idx=3 and opnd_drive=1. Then busreq->0001 with rd_idx=3: rd_data=6 one edge later.
- Push 2 and 4, then issue NEXT_OPERAND twice (busreq toggled through 0000): opnd_idx=2 then 4. A third request gives 3 (default). q_empty=1 at the end.
- wb_en=1, wb_idx=3, core_result=8, core_carry=1, core_done 0->1 held for 5 cycles: R3=8 written once, carry_flag=1. A subsequent READ_REG of R3 returns 8.
- Same-edge host write R3=0xF and write-back R3=0x5: R3=5. host_rdata for address 3 reads 5.
- Push 5 entries with QDEPTH=4: q_full=1 after 4, err=1 after the 5th, and pops return the first 4 values in order. busreq=0101: err stays 1 with no state change.
- Assert rst_n=0 for 1ns mid-READ_REG while busreq=0001 is held: outputs return to 0. After release, rd_data=reg[rd_idx] (0 after reset) one edge later.

Source files
------------

// File: rtl/alu_bus_responder.sv
// alu_bus_responder: responder for the 4-bit ALU core's BUSREQ protocol.
// Serves operand indices from a host-loaded FIFO and register reads from a
// local register file. It also captures the core's result and carry when the
// core raises done.
module alu_bus_responder #(
    parameter int          DEPTH        = 16,
    parameter int          QDEPTH       = 4,
    parameter logic [3:0]  DEFAULT_OPND = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] busreq,
    input  logic [3:0] rd_idx,
    output logic [3:0] opnd_idx,
    output logic       opnd_drive,
    output logic [3:0] rd_data,
    input  logic       core_done,
    input  logic       core_carry,
    input  logic [3:0] core_result,
    input  logic       wb_en,
    input  logic [3:0] wb_idx,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [3:0] host_wdata,
    output logic [3:0] host_rdata,
    input  logic       q_push,
    input  logic [3:0] q_wdata,
    output logic       q_full,
    output logic       q_empty,
    output logic       carry_flag,
    output logic       err
);

    // Register index width; upper index bits alias modulo DEPTH.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // FIFO address width; pointers carry one extra wrap bit.
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [3:0] REQ_IDLE = 4'b0000;
    localparam logic [3:0] REQ_READ = 4'b0001;
    localparam logic [3:0] REQ_NEXT = 4'b0011;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Map a 4-bit register index onto the implemented register file.
    function automatic logic [IW-1:0] reg_sel(input logic [3:0] idx);
        reg_sel = idx[IW-1:0];
    endfunction

    logic [3:0]  regs_r [DEPTH];
    logic [3:0]  fifo_r [QDEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [3:0]  busreq_q_r;
    logic        done_q_r;
    logic [3:0]  opnd_idx_r;
    logic        opnd_drive_r;
    logic [3:0]  rd_data_r;
    logic        carry_flag_r;
    logic        err_r;

    logic        accept_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        pop_s;
    logic        push_ok_s;
    logic        push_drop_s;
    logic        bad_code_s;
    logic        wb_fire_s;

    // Request edge detect, FIFO status and the push/pop/error decisions.
    always_comb begin
        accept_s     = (busreq != busreq_q_r);
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        // The pop is decided first, so a full FIFO can accept a push on the
        // same edge. An empty FIFO never pops, even if a push arrives.
        pop_s        = accept_s && (busreq == REQ_NEXT) && !fifo_empty_s;
        push_ok_s    = q_push && (!fifo_full_s || pop_s);
        push_drop_s  = q_push && fifo_full_s && !pop_s;
        wb_fire_s    = core_done && !done_q_r;
        bad_code_s   = 1'b0;
        if (accept_s) begin
            case (busreq)
                REQ_IDLE: bad_code_s = 1'b0;
                REQ_READ: bad_code_s = 1'b0;
                REQ_NEXT: bad_code_s = 1'b0;
                default:  bad_code_s = 1'b1;
            endcase
        end else begin
            bad_code_s = 1'b0;
        end
    end

    // Bus request servicing, edge samplers, carry capture and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busreq_q_r   <= 4'd0;
            done_q_r     <= 1'b0;
            opnd_idx_r   <= 4'd0;
            opnd_drive_r <= 1'b0;
            rd_data_r    <= 4'd0;
            carry_flag_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            busreq_q_r <= busreq;
            done_q_r   <= core_done;
            if (accept_s) begin
                case (busreq)
                    REQ_IDLE: opnd_drive_r <= 1'b0;
                    REQ_NEXT: begin
                        opnd_idx_r   <= pop_s ? fifo_r[rd_ptr_r[AW-1:0]] : DEFAULT_OPND;
                        opnd_drive_r <= 1'b1;
                    end
                    // Reads the pre-write value; same-edge writes are not bypassed.
                    REQ_READ: rd_data_r <= regs_r[reg_sel(rd_idx)];
                    default:  opnd_drive_r <= opnd_drive_r;
                endcase
            end
            if (wb_fire_s) begin
                carry_flag_r <= core_carry;
            end
            if (bad_code_s || push_drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Register file: host write, then core write-back so the latter wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= 4'd0;
            end
        end else begin
            if (host_we) begin
                regs_r[reg_sel(host_addr)] <= host_wdata;
            end
            if (wb_fire_s && wb_en) begin
                regs_r[reg_sel(wb_idx)] <= core_result;
            end
        end
    end

    // Operand-index FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_r[i] <= 4'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                fifo_r[wr_ptr_r[AW-1:0]] <= q_wdata;
                wr_ptr_r                 <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign opnd_idx   = opnd_idx_r;
    assign opnd_drive = opnd_drive_r;
    assign rd_data    = rd_data_r;
    assign carry_flag = carry_flag_r;
    assign err        = err_r;
    assign q_full     = fifo_full_s;
    assign q_empty    = fifo_empty_s;
    assign host_rdata = regs_r[reg_sel(host_addr)];

endmodule

// File: tb/tb_alu_bus_responder.sv
// Self-checking bench for alu_bus_responder. The bench runs directed scenarios
// followed by randomized traffic. Every edge is compared against a
// behavioural model built from a queue and a register array.
module tb_alu_bus_responder;

    localparam int DEPTH  = 16;
    localparam int QDEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] busreq;
    logic [3:0] rd_idx;
    logic [3:0] opnd_idx;
    logic       opnd_drive;
    logic [3:0] rd_data;
    logic       core_done;
    logic       core_carry;
    logic [3:0] core_result;
    logic       wb_en;
    logic [3:0] wb_idx;
    logic       host_we;
    logic [3:0] host_addr;
    logic [3:0] host_wdata;
    logic [3:0] host_rdata;
    logic       q_push;
    logic [3:0] q_wdata;
    logic       q_full;
    logic       q_empty;
    logic       carry_flag;
    logic       err;

    alu_bus_responder #(.DEPTH(DEPTH), .QDEPTH(QDEPTH), .DEFAULT_OPND(4'd3)) dut (
        .clk(clk), .rst_n(rst_n), .busreq(busreq), .rd_idx(rd_idx),
        .opnd_idx(opnd_idx), .opnd_drive(opnd_drive), .rd_data(rd_data),
        .core_done(core_done), .core_carry(core_carry), .core_result(core_result),
        .wb_en(wb_en), .wb_idx(wb_idx), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .q_push(q_push),
        .q_wdata(q_wdata), .q_full(q_full), .q_empty(q_empty),
        .carry_flag(carry_flag), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_regs [DEPTH];
    logic [3:0] m_fifo [$];
    logic [3:0] m_prev_req;
    logic       m_prev_done;
    logic [3:0] m_opnd;
    logic       m_drive;
    logic [3:0] m_rd;
    logic       m_carry;
    logic       m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 4'd0;
        m_fifo.delete();
        m_prev_req  = 4'd0;
        m_prev_done = 1'b0;
        m_opnd      = 4'd0;
        m_drive     = 1'b0;
        m_rd        = 4'd0;
        m_carry     = 1'b0;
        m_err       = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit         new_req;
        bit         done_rise;
        logic [3:0] old_regs [DEPTH];
        new_req   = (busreq != m_prev_req);
        done_rise = core_done && !m_prev_done;
        for (int i = 0; i < DEPTH; i++) old_regs[i] = m_regs[i];
        if (new_req) begin
            if (busreq == 4'd0) begin
                m_drive = 1'b0;
            end else if (busreq == 4'd3) begin
                m_opnd  = (m_fifo.size() > 0) ? m_fifo.pop_front() : 4'd3;
                m_drive = 1'b1;
            end else if (busreq == 4'd1) begin
                m_rd = old_regs[rd_idx % DEPTH];
            end else begin
                m_err = 1'b1;
            end
        end
        if (q_push) begin
            if (m_fifo.size() < QDEPTH) m_fifo.push_back(q_wdata);
            else m_err = 1'b1;
        end
        if (host_we) m_regs[host_addr % DEPTH] = host_wdata;
        if (done_rise) begin
            m_carry = core_carry;
            if (wb_en) m_regs[wb_idx % DEPTH] = core_result;
        end
        m_prev_req  = busreq;
        m_prev_done = core_done;
    endtask

    task automatic compare_all();
        check_val("opnd_idx",   32'(opnd_idx),   32'(m_opnd));
        check_val("opnd_drive", 32'(opnd_drive), 32'(m_drive));
        check_val("rd_data",    32'(rd_data),    32'(m_rd));
        check_val("carry_flag", 32'(carry_flag), 32'(m_carry));
        check_val("err",        32'(err),        32'(m_err));
        check_val("q_full",     32'(q_full),     32'(m_fifo.size() == QDEPTH));
        check_val("q_empty",    32'(q_empty),    32'(m_fifo.size() == 0));
        check_val("host_rdata", 32'(host_rdata), 32'(m_regs[host_addr % DEPTH]));
    endtask

    // One clock: model the edge, let the DUT take it, then compare off-edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [3:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        cycle();
        host_we = 1'b0;
    endtask

    task automatic request(input logic [3:0] code);
        busreq = code;
        cycle();
    endtask

    task automatic push(input logic [3:0] v);
        q_push = 1'b1; q_wdata = v;
        cycle();
        q_push = 1'b0;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; busreq = 4'd0; rd_idx = 4'd0; core_done = 1'b0;
        core_carry = 1'b0; core_result = 4'd0; wb_en = 1'b0; wb_idx = 4'd0;
        host_we = 1'b0; host_addr = 4'd0; host_wdata = 4'd0; q_push = 1'b0;
        q_wdata = 4'd0;
        #12;
        model_reset();
        compare_all();
        check_val("reset_q_empty", 32'(q_empty), 32'd1);
        rst_n = 1'b1;

        // Host loads, default operand, then read of the presented index
        host_write(4'd1, 4'd4);
        host_write(4'd2, 4'd5);
        host_write(4'd3, 4'd6);
        host_write(4'd4, 4'd3);
        request(4'd3);
        check_val("default_opnd", 32'(opnd_idx), 32'd3);
        check_val("drive_on", 32'(opnd_drive), 32'd1);
        rd_idx = 4'd3;
        request(4'd1);
        check_val("read_r3", 32'(rd_data), 32'd6);
        check_val("drive_hold", 32'(opnd_drive), 32'd1);
        request(4'd1);
        check_val("held_no_reservice", 32'(rd_data), 32'd6);
        request(4'd0);
        check_val("idle_drive_off", 32'(opnd_drive), 32'd0);

        // FIFO order then default
        push(4'd2);
        push(4'd4);
        request(4'd3); check_val("fifo_pop1", 32'(opnd_idx), 32'd2);
        request(4'd0);
        request(4'd3); check_val("fifo_pop2", 32'(opnd_idx), 32'd4);
        request(4'd0);
        request(4'd3); check_val("fifo_default", 32'(opnd_idx), 32'd3);
        check_val("fifo_drained", 32'(q_empty), 32'd1);
        request(4'd0);

        // Write-back fires once on the rising edge of done
        wb_en = 1'b1; wb_idx = 4'd3; core_result = 4'd8; core_carry = 1'b1; core_done = 1'b1;
        cycle();
        core_result = 4'd9; core_carry = 1'b0;
        repeat (4) cycle();
        core_done = 1'b0;
        cycle();
        host_addr = 4'd3;
        #1;
        check_val("wb_once", 32'(host_rdata), 32'd8);
        check_val("wb_carry", 32'(carry_flag), 32'd1);
        rd_idx = 4'd3;
        request(4'd1);
        check_val("read_after_wb", 32'(rd_data), 32'd8);
        request(4'd0);

        // Same-address host write vs write-back
        host_we = 1'b1; host_addr = 4'd3; host_wdata = 4'hF;
        core_result = 4'd5; core_done = 1'b1;
        cycle();
        host_we = 1'b0; core_done = 1'b0;
        check_val("wb_wins", 32'(host_rdata), 32'd5);
        cycle();
        // Different addresses: both land
        host_we = 1'b1; host_addr = 4'd2; host_wdata = 4'hA;
        wb_idx = 4'd4; core_result = 4'd7; core_done = 1'b1;
        cycle();
        host_we = 1'b0; core_done = 1'b0;
        check_val("both_host", 32'(host_rdata), 32'hA);
        host_addr = 4'd4;
        cycle();
        check_val("both_wb", 32'(host_rdata), 32'd7);

        // Read racing a write to the same index returns the old value
        rd_idx = 4'd2; host_we = 1'b1; host_addr = 4'd2; host_wdata = 4'd1;
        request(4'd1);
        host_we = 1'b0;
        check_val("read_no_bypass", 32'(rd_data), 32'hA);
        request(4'd0);

        // Full FIFO: push and pop on the same edge is accepted without error
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        check_val("full_at_4", 32'(q_full), 32'd1);
        q_push = 1'b1; q_wdata = 4'd9;
        request(4'd3);
        q_push = 1'b0;
        check_val("full_pushpop_opnd", 32'(opnd_idx), 32'd1);
        check_val("full_pushpop_err", 32'(err), 32'd0);
        check_val("full_pushpop_full", 32'(q_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            request(4'd0);
            request(4'd3);
        end
        check_val("drain_last", 32'(opnd_idx), 32'd9);
        request(4'd0);
        // Empty FIFO: pop takes default, push is still stored
        q_push = 1'b1; q_wdata = 4'd6;
        request(4'd3);
        q_push = 1'b0;
        check_val("empty_pushpop_opnd", 32'(opnd_idx), 32'd3);
        check_val("empty_pushpop_stored", 32'(q_empty), 32'd0);
        request(4'd0);
        request(4'd3);
        check_val("empty_pushpop_pop", 32'(opnd_idx), 32'd6);
        request(4'd0);

        // Overflow: fifth push dropped and flagged
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 10));
            if (i == 3) check_val("ovf_full", 32'(q_full), 32'd1);
        end
        check_val("ovf_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            request(4'd3);
            check_val("ovf_pop", 32'(opnd_idx), 32'(i + 10));
            request(4'd0);
        end
        request(4'd5);
        check_val("bad_code_err", 32'(err), 32'd1);
        request(4'd0);

        // Reset mid-request with READ_REG held
        rd_idx = 4'd4;
        request(4'd1);
        check_val("pre_reset_rd", 32'(rd_data), 32'd7);
        pulse_reset();
        check_val("reset_rd", 32'(rd_data), 32'd0);
        check_val("reset_err", 32'(err), 32'd0);
        cycle();
        check_val("reaccept_rd", 32'(rd_data), 32'd0);

        // Randomized traffic against the model
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) busreq = 4'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 2))
                    0: busreq = 4'd0;
                    1: busreq = 4'd1;
                    default: busreq = 4'd3;
                endcase
            end
            rd_idx      = 4'($urandom_range(0, 15));
            q_push      = ($urandom_range(0, 2) == 0);
            q_wdata     = 4'($urandom_range(0, 15));
            host_we     = ($urandom_range(0, 3) == 0);
            host_addr   = 4'($urandom_range(0, 15));
            host_wdata  = 4'($urandom_range(0, 15));
            core_done   = ($urandom_range(0, 2) == 0);
            core_carry  = 1'($urandom_range(0, 1));
            core_result = 4'($urandom_range(0, 15));
            wb_en       = 1'($urandom_range(0, 1));
            wb_idx      = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
